// File: rtl/starfield_ramp.sv
`default_nettype none
// ============================================================================
// Module   : starfield_ramp
// Brief    : Ramps the starfield speed register toward a commanded target,
//            one step per FRAMES_PER_STEP vblank rising edges, after writing
//            the enable register. Optional STARFIELD_RAMP_HOLD_EN adds a
//            'hold' input that freezes the ramp while high.
// Revision : 1.0
// ============================================================================
module starfield_ramp #(
    parameter int         FRAMES_PER_STEP = 1,
    parameter logic [7:0] INIT_SPEED      = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblank,
`ifdef STARFIELD_RAMP_HOLD_EN
    input  logic       hold,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    input  logic       cmd_enable,
    output logic       sf_addr,
    output logic [7:0] sf_data,
    output logic       sf_write,
    output logic [7:0] cur_speed,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_EN   = 2'd1,
        S_WAIT_VB = 2'd2,
        S_WR_SPD  = 2'd3
    } state_t;

    localparam logic [7:0] C_LAST_EDGE = 8'(FRAMES_PER_STEP - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_target;
    logic [7:0] r_step;
    logic       r_enable;
    logic [7:0] r_speed;
    logic       r_vblank;
    logic [7:0] r_edge_cnt;

    logic       w_hold;
    logic       w_vb_edge;
    logic       w_edge_counted;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_step_speed;

`ifdef STARFIELD_RAMP_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_vb_edge      = vblank & ~r_vblank;
    assign w_edge_counted = (r_state == S_WAIT_VB) && w_vb_edge && !w_hold;
    assign cur_speed      = r_speed;

    // 9-bit intermediates so a large step can never wrap past 0 or 255.
    assign w_sum  = {1'b0, r_speed} + {1'b0, r_step};
    assign w_diff = {1'b0, r_speed} - {1'b0, r_step};

    always_comb begin
        w_step_speed = r_target;
        if (r_step != 8'd0) begin
            if (r_speed < r_target) begin
                w_step_speed = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[7:0];
            end else begin
                w_step_speed = (w_diff[8] || (w_diff[7:0] <= r_target)) ? r_target : w_diff[7:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        sf_write     = 1'b0;
        sf_addr      = 1'b0;
        sf_data      = 8'd0;
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = S_WR_EN;
                end
            end
            S_WR_EN: begin
                sf_write     = 1'b1;
                sf_addr      = 1'b1;
                sf_data      = {7'b0, r_enable};
                w_next_state = S_WAIT_VB;
            end
            S_WAIT_VB: begin
                if (r_speed == r_target) begin
                    w_next_state = S_IDLE;
                end else if (w_edge_counted && (r_edge_cnt == C_LAST_EDGE)) begin
                    w_next_state = S_WR_SPD;
                end
            end
            S_WR_SPD: begin
                sf_write     = 1'b1;
                sf_data      = r_speed;
                w_next_state = S_WAIT_VB;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_target   <= 8'd0;
            r_step     <= 8'd0;
            r_enable   <= 1'b0;
            r_speed    <= INIT_SPEED;
            r_vblank   <= 1'b0;
            r_edge_cnt <= 8'd0;
        end else begin
            r_state  <= w_next_state;
            r_vblank <= vblank;
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_target <= cmd_target;
                r_step   <= cmd_step;
                r_enable <= cmd_enable;
            end
            // Held at zero outside WAIT_VB, so every entry starts a fresh count.
            if (r_state != S_WAIT_VB) begin
                r_edge_cnt <= 8'd0;
            end else if (w_edge_counted && (r_speed != r_target)) begin
                r_edge_cnt <= (r_edge_cnt == C_LAST_EDGE) ? 8'd0 : r_edge_cnt + 8'd1;
            end
            // cur_speed takes the new value as the write is issued.
            if ((r_state == S_WAIT_VB) && (w_next_state == S_WR_SPD)) begin
                r_speed <= w_step_speed;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_starfield_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_starfield_ramp
// Brief    : Directed self-checking bench for starfield_ramp (default and
//            FRAMES_PER_STEP=3 instances; hold test when the macro is set).
// Revision : 1.0
// ============================================================================
module tb_starfield_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblank, cmd_valid, cmd_enable;
    logic [7:0] cmd_target, cmd_step;
    logic       cmd_ready, sf_addr, sf_write, busy;
    logic [7:0] sf_data, cur_speed;

    logic       vblank3, cmd_valid3, cmd_enable3;
    logic [7:0] cmd_target3, cmd_step3;
    logic       cmd_ready3, sf_addr3, sf_write3, busy3;
    logic [7:0] sf_data3, cur_speed3;
`ifdef STARFIELD_RAMP_HOLD_EN
    logic       hold;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int viol    = 0;
    logic prev_wr = 1'b0;
    logic [8:0] wr_log[$];

    always #5 clk = ~clk;

    starfield_ramp u_dut (
        .clk(clk), .rst(rst), .vblank(vblank),
`ifdef STARFIELD_RAMP_HOLD_EN
        .hold(hold),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_step(cmd_step), .cmd_enable(cmd_enable), .sf_addr(sf_addr),
        .sf_data(sf_data), .sf_write(sf_write), .cur_speed(cur_speed), .busy(busy)
    );

    starfield_ramp #(.FRAMES_PER_STEP(3)) u_dut3 (
        .clk(clk), .rst(rst), .vblank(vblank3),
`ifdef STARFIELD_RAMP_HOLD_EN
        .hold(1'b0),
`endif
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_target(cmd_target3),
        .cmd_step(cmd_step3), .cmd_enable(cmd_enable3), .sf_addr(sf_addr3),
        .sf_data(sf_data3), .sf_write(sf_write3), .cur_speed(cur_speed3), .busy(busy3)
    );

    // Write log and bus-protocol watcher for the main instance.
    always @(negedge clk) begin
        if (sf_write) wr_log.push_back({sf_addr, sf_data});
        if (sf_write && prev_wr) viol++;
        if (!sf_write && (sf_addr || (sf_data != 8'd0))) viol++;
        prev_wr = sf_write;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_log(input string tag, input logic a, input logic [7:0] d);
        logic [31:0] got;
        got = 32'hDEAD;
        if (wr_log.size() > 0) got = {23'd0, wr_log.pop_front()};
        check(tag, got, {23'd0, a, d});
    endtask

    task automatic send(input bit sel, input logic [7:0] tgt, input logic [7:0] stp, input logic en);
        if (sel) begin
            cmd_valid3 = 1'b1; cmd_target3 = tgt; cmd_step3 = stp; cmd_enable3 = en;
        end else begin
            cmd_valid = 1'b1; cmd_target = tgt; cmd_step = stp; cmd_enable = en;
        end
        @(negedge clk);
        check("cmd_ready_idle", sel ? cmd_ready3 : cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
    endtask

    // One vblank rising edge; samples the bus one cycle after the edge is registered.
    task automatic vb_pulse(input bit sel, output logic wr, output logic [7:0] d);
        if (sel) vblank3 = 1'b1; else vblank = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = sel ? sf_write3 : sf_write;
        d  = sel ? sf_data3  : sf_data;
        vblank  = 1'b0;
        vblank3 = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       wr;
        logic [7:0] d;
        logic [5:0] pat;
        int         nwr;

        rst = 1'b1;
        vblank = 0; cmd_valid = 0; cmd_target = 0; cmd_step = 0; cmd_enable = 0;
        vblank3 = 0; cmd_valid3 = 0; cmd_target3 = 0; cmd_step3 = 0; cmd_enable3 = 0;
`ifdef STARFIELD_RAMP_HOLD_EN
        hold = 1'b0;
`endif
        tick(2);
        check("rst_sf_write", sf_write, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cur_speed", cur_speed, 0);
        check("rst_addr_data", {sf_addr, sf_data}, 0);
        rst = 1'b0;
        tick(2);

        // Ramp up 0 -> 32 by 8.
        send(0, 8'd32, 8'd8, 1'b1);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            vb_pulse(0, wr, d);
            check("up_latency", wr, 1);
            check("up_data", d, 8 * (i + 1));
        end
        tick(2);
        check("up_cur", cur_speed, 32);
        check("up_idle", busy, 0);
        pop_log("up_en", 1'b1, 8'h01);
        pop_log("up_s8", 1'b0, 8'd8);
        pop_log("up_s16", 1'b0, 8'd16);
        pop_log("up_s24", 1'b0, 8'd24);
        pop_log("up_s32", 1'b0, 8'd32);

        // Ramp down 32 -> 5 by 10 with clamp.
        send(0, 8'd5, 8'd10, 1'b0);
        tick(3);
        for (int i = 0; i < 3; i++) begin
            vb_pulse(0, wr, d);
            check("dn_latency", wr, 1);
        end
        vb_pulse(0, wr, d);
        check("dn_no_extra", wr, 0);
        check("dn_cur", cur_speed, 5);
        pop_log("dn_en", 1'b1, 8'h00);
        pop_log("dn_s22", 1'b0, 8'd22);
        pop_log("dn_s12", 1'b0, 8'd12);
        pop_log("dn_s5", 1'b0, 8'd5);

        // Target equals current speed: enable write only.
        send(0, 8'd5, 8'd3, 1'b1);
        tick(4);
        check("eq_idle", busy, 0);
        pop_log("eq_en", 1'b1, 8'h01);
        check("eq_no_speed", wr_log.size(), 0);

        // Step 0 jumps; then a step that would wrap 8 bits clamps instead.
        send(0, 8'd200, 8'd0, 1'b0);
        tick(3);
        vb_pulse(0, wr, d);
        tick(2);
        check("jump_idle", busy, 0);
        pop_log("jump_en", 1'b1, 8'h00);
        pop_log("jump_s200", 1'b0, 8'd200);
        send(0, 8'd250, 8'd100, 1'b1);
        tick(3);
        vb_pulse(0, wr, d);
        tick(2);
        check("wrap_cur", cur_speed, 250);
        pop_log("wrap_en", 1'b1, 8'h01);
        pop_log("wrap_s250", 1'b0, 8'd250);

        // Command while busy is ignored; ramp 250 -> 0 by 50 continues.
        send(0, 8'd0, 8'd50, 1'b1);
        tick(3);
        vb_pulse(0, wr, d);
        cmd_valid = 1'b1; cmd_target = 8'd255; cmd_step = 8'd1; cmd_enable = 1'b0;
        @(negedge clk);
        check("busy_ready_low", cmd_ready, 0);
        check("busy_high", busy, 1);
        tick(2);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) vb_pulse(0, wr, d);
        tick(2);
        check("ign_cur", cur_speed, 0);
        pop_log("ign_en", 1'b1, 8'h01);
        pop_log("ign_s200", 1'b0, 8'd200);
        pop_log("ign_s150", 1'b0, 8'd150);
        pop_log("ign_s100", 1'b0, 8'd100);
        pop_log("ign_s50", 1'b0, 8'd50);
        pop_log("ign_s0", 1'b0, 8'd0);
        check("ign_log_empty", wr_log.size(), 0);

        // Reset mid-ramp abandons the command.
        send(0, 8'd100, 8'd10, 1'b1);
        tick(3);
        vb_pulse(0, wr, d);
        rst = 1'b1;
        #1;
        check("mid_rst_write", sf_write, 0);
        check("mid_rst_cur", cur_speed, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        tick(2);
        rst = 1'b0;
        tick(2);
        nwr = 0;
        for (int i = 0; i < 3; i++) begin
            vb_pulse(0, wr, d);
            nwr += int'(wr);
        end
        check("post_rst_writes", nwr, 0);
        pop_log("mid_en", 1'b1, 8'h01);
        pop_log("mid_s10", 1'b0, 8'd10);
        check("mid_log_empty", wr_log.size(), 0);

        // FRAMES_PER_STEP=3: writes on edges 3 and 6 only.
        send(1, 8'd2, 8'd1, 1'b1);
        tick(3);
        pat = 6'd0;
        for (int i = 0; i < 6; i++) begin
            vb_pulse(1, wr, d);
            pat[i] = wr;
            if (i == 2) check("f3_s1", d, 1);
            if (i == 5) check("f3_s2", d, 2);
        end
        tick(2);
        check("f3_pattern", pat, 6'b100100);
        check("f3_cur", cur_speed3, 2);
        check("f3_idle", busy3, 0);

`ifdef STARFIELD_RAMP_HOLD_EN
        send(0, 8'd10, 8'd5, 1'b1);
        tick(3);
        hold = 1'b1;
        nwr = 0;
        for (int i = 0; i < 4; i++) begin
            vb_pulse(0, wr, d);
            nwr += int'(wr);
        end
        check("hold_no_writes", nwr, 0);
        hold = 1'b0;
        vb_pulse(0, wr, d);
        check("hold_resume", {wr, d}, {1'b1, 8'd5});
        vb_pulse(0, wr, d);
        check("hold_final", {wr, d}, {1'b1, 8'd10});
        pop_log("hold_en", 1'b1, 8'h01);
        pop_log("hold_s5", 1'b0, 8'd5);
        pop_log("hold_s10", 1'b0, 8'd10);
`endif

        check("log_empty", wr_log.size(), 0);
        check("bus_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
